// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHK_EN.
package dmem_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_LSB   = 2;   // byte address -> word address shift
  localparam int unsigned BYTE_ADDR_W = 32;

  typedef enum logic {
    ST_NORMAL,
    ST_FORCE
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DBG
  } owner_e;

  function automatic logic addr_misaligned(input logic [ADDR_LSB-1:0] lsb);
    return lsb != '0;
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive debug denials; hit flags that the next denial is the
// STARVE_MAX-th one and must trigger a forced debug slot.
module dmem_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic deny,
  input  logic clear,
  output logic hit
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (deny) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign hit = (cnt == CW'(STARVE_MAX - 1));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage has fixed priority, debug
// port gets a forced slot after STARVE_MAX denials. Macro: DMEM_ALIGN_CHK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  state_e            state, state_nx;
  owner_e            owner;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;
  logic              bad;
  logic              deny;
  logic              clear;
  logic              hit;
  logic              dbg_rd;
  logic              addr_unused;

  // Owner is forced to none while reset is held, which also zeroes every
  // strobe and the memory mux without a separate reset gate on each output.
  always_comb begin
    owner = OWN_NONE;
    if (rst_i) begin
      case (state)
        ST_NORMAL: begin
          if (cpu_req_i)      owner = OWN_CPU;
          else if (dbg_req_i) owner = OWN_DBG;
        end
        ST_FORCE: begin
          if (dbg_req_i)      owner = OWN_DBG;
          else if (cpu_req_i) owner = OWN_CPU;
        end
        default: owner = OWN_NONE;
      endcase
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (owner)
      OWN_CPU: begin
        sel_we    = cpu_we_i;
        sel_addr  = cpu_addr_i;
        sel_wdata = cpu_wdata_i;
      end
      OWN_DBG: begin
        sel_we    = dbg_we_i;
        sel_addr  = dbg_addr_i;
        sel_wdata = dbg_wdata_i;
      end
      default: ;
    endcase
  end

`ifdef DMEM_ALIGN_CHK_EN
  assign bad = (owner != OWN_NONE) && addr_misaligned(sel_addr[ADDR_LSB-1:0]);
`else
  assign bad = 1'b0;
`endif

  assign addr_unused = ^{sel_addr[BYTE_ADDR_W-1:ADDR_W+ADDR_LSB], sel_addr[ADDR_LSB-1:0]};

  assign deny  = (state == ST_NORMAL) && (owner == OWN_CPU) && dbg_req_i;
  assign clear = (owner == OWN_DBG) || !dbg_req_i || (state == ST_FORCE);

  dmem_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .deny  (deny),
    .clear (clear),
    .hit   (hit)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= ST_NORMAL;
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      state        <= state_nx;
      dbg_rvalid_o <= dbg_rd;
      if (dbg_rd) dbg_rdata_o <= rd_data;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_NORMAL: if (deny && hit) state_nx = ST_FORCE;
      ST_FORCE:  state_nx = ST_NORMAL;
      default:   state_nx = ST_NORMAL;
    endcase
  end

  always_comb begin
    rd_data     = bad ? '0 : mem_rdata_i;
    dbg_rd      = (owner == OWN_DBG) && !dbg_we_i;
    mem_en_o    = (owner != OWN_NONE);
    mem_we_o    = sel_we && !bad;
    mem_addr_o  = sel_addr[ADDR_W+ADDR_LSB-1:ADDR_LSB];
    mem_wdata_o = sel_wdata;
    cpu_rdata_o = (owner == OWN_CPU) ? rd_data : '0;
    dbg_gnt_o   = (owner == OWN_DBG);
    cpu_stall_o = (state == ST_FORCE) && (owner == OWN_DBG) && cpu_req_i;
  end

`ifdef DMEM_ALIGN_CHK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i)   err_o <= 1'b0;
    else if (bad) err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// starvation/reset/alignment sequences, then random traffic vs. a reference model.
module tb_dmem_arbiter;

  localparam int SM = 4;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_gnt, dbg_rvalid, mem_en, mem_we, err;
  logic [4:0]  mem_addr;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
    .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rdata_o(dbg_rdata),
    .dbg_rvalid_o(dbg_rvalid), .mem_en_o(mem_en), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, synchronous write.
  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_force;
  int          m_deny;
  logic        m_rvalid, m_err;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [32];
  int          e_own;      // 0 none, 1 cpu, 2 dbg
  int          e_idx;
  logic        e_bad, e_en, e_we, e_gnt, e_stall;
  logic [31:0] e_wdata, e_crd;

  task automatic model_eval();
    logic [31:0] a;
    e_own = 0;
    if (rst === 1'b1) begin
      if (m_force) e_own = dbg_req ? 2 : (cpu_req ? 1 : 0);
      else         e_own = cpu_req ? 1 : (dbg_req ? 2 : 0);
    end
    a       = (e_own == 1) ? cpu_addr : dbg_addr;
    e_idx   = (e_own == 0) ? 0 : int'((a >> 2) % 32);
    e_bad   = ALIGN && (e_own != 0) && ((a % 4) != 0);
    e_en    = (e_own != 0);
    e_we    = ((e_own == 1) ? cpu_we : (e_own == 2) ? dbg_we : 1'b0) && !e_bad;
    e_wdata = (e_own == 1) ? cpu_wdata : (e_own == 2) ? dbg_wdata : 32'd0;
    e_gnt   = (e_own == 2);
    e_stall = m_force && (e_own == 2) && cpu_req;
    e_crd   = (e_own == 1 && !e_bad) ? ref_mem[e_idx] : 32'd0;
  endtask

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      m_force = 0; m_deny = 0; m_rvalid = 0; m_rdata = 0; m_err = 0;
    end else begin
      model_eval();
      m_rvalid = (e_own == 2) && !dbg_we;
      if (m_rvalid) m_rdata = e_bad ? 32'd0 : ref_mem[e_idx];
      if (e_bad) m_err = 1'b1;
      if (e_we) ref_mem[e_idx] = e_wdata;
      if (m_force) begin
        m_force = 0; m_deny = 0;
      end else if (e_own == 1 && dbg_req) begin
        m_deny++;
        if (m_deny >= SM) begin m_force = 1; m_deny = 0; end
      end else begin
        m_deny = 0;
      end
    end
  end

  // Apply one cycle of inputs at the negedge and evaluate the model.
  task automatic drive(input logic r, input logic cr, input logic cw,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #2;
    model_eval();
  endtask

  task automatic chk_model();
    chk("en", mem_en, e_en);
    chk("we", mem_we, e_we);
    chk("gnt", dbg_gnt, e_gnt);
    chk("stall", cpu_stall, e_stall);
    chk("rvalid", dbg_rvalid, m_rvalid);
    chk("dbg_rdata", dbg_rdata, m_rdata);
    chk("err", err, m_err);
    if (rst) begin
      chk("addr", mem_addr, e_idx[4:0]);
      chk("wdata", mem_wdata, e_wdata);
      chk("cpu_rdata", cpu_rdata, e_crd);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
    return a;
  endfunction

  typedef struct {
    logic cr, cw; logic [31:0] ca, cd;
    logic dr, dw; logic [31:0] da, dd;
    logic en, we; logic [4:0] addr; logic [31:0] wdata;
    logic gnt, stall; logic [31:0] crd; logic rvalid; logic [31:0] drd;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic        d_req, d_we, last_gnt;
    logic [31:0] d_addr, d_wdata;

    rst = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    mem[1] = 6; mem[4] = 29;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

    //         cr cw ca     cd  dr dw da      dd  en we ad wd  gnt st crd     rv drd
    tbl[0] = '{1, 0, 32'h04, 0, 1, 1, 32'h0C, 77, 1, 0, 1, 0,  0, 0, 6,      0, 0};
    tbl[1] = '{0, 0, 32'h00, 0, 1, 1, 32'h0C, 77, 1, 1, 3, 77, 1, 0, 0,      0, 0};
    for (int i = 2; i < 6; i++)
      tbl[i] = '{1, 0, 32'h00, 0, 1, 0, 32'h10, 0, 1, 0, 0, 0, 0, 0, 32'h100, 0, 0};
    tbl[6] = '{1, 0, 32'h00, 0, 1, 0, 32'h10, 0,  1, 0, 4, 0,  1, 1, 0,      0, 0};
    tbl[7] = '{1, 0, 32'h00, 0, 0, 0, 32'h00, 0,  1, 0, 0, 0,  0, 0, 32'h100, 1, 29};
    tbl[8] = '{1, 1, 32'h08, 55, 0, 0, 32'h00, 0, 1, 1, 2, 55, 0, 0, 32'h102, 0, 0};
    tbl[9] = '{1, 0, 32'h0C, 0, 0, 0, 32'h00, 0,  1, 0, 3, 0,  0, 0, 77,     0, 0};

    // Reset held with both requesters active.
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 32'h04, 0, 1, 0, 32'h10, 0);
      chk("rst_en", mem_en, 0);
      chk("rst_gnt", dbg_gnt, 0);
      chk("rst_stall", cpu_stall, 0);
      chk("rst_rvalid", dbg_rvalid, 0);
    end

    foreach (tbl[i]) begin
      drive(1, tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd,
            tbl[i].dr, tbl[i].dw, tbl[i].da, tbl[i].dd);
      chk($sformatf("v%0d_en", i), mem_en, tbl[i].en);
      chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
      chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].wdata);
      chk($sformatf("v%0d_gnt", i), dbg_gnt, tbl[i].gnt);
      chk($sformatf("v%0d_stall", i), cpu_stall, tbl[i].stall);
      chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].crd);
      chk($sformatf("v%0d_rvalid", i), dbg_rvalid, tbl[i].rvalid);
      if (tbl[i].rvalid) chk($sformatf("v%0d_dbg_rdata", i), dbg_rdata, tbl[i].drd);
    end

    // Debug drops its request in the FORCE cycle; the counter must restart.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 1, 0, 32'h10, 0);
      chk("drop_deny_gnt", dbg_gnt, 0);
    end
    drive(1, 1, 0, 32'h0C, 0, 0, 0, 0, 0);
    chk("drop_en", mem_en, 1);
    chk("drop_gnt", dbg_gnt, 0);
    chk("drop_stall", cpu_stall, 0);
    chk("drop_cpu_rdata", cpu_rdata, 77);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0, 0, 1, 0, 32'h10, 0);
      chk("redeny_gnt", dbg_gnt, 0);
      chk("redeny_stall", cpu_stall, 0);
    end
    drive(1, 1, 0, 0, 0, 1, 0, 32'h10, 0);
    chk("reforce_gnt", dbg_gnt, 1);
    chk("reforce_stall", cpu_stall, 1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("reforce_rdata", dbg_rdata, 29);

    // Reset arriving during the FORCE cycle.
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 0, 1, 0, 32'h10, 0);
    drive(0, 1, 0, 0, 0, 1, 0, 32'h10, 0);
    chk("rstf_en", mem_en, 0);
    chk("rstf_gnt", dbg_gnt, 0);
    chk("rstf_stall", cpu_stall, 0);
    drive(1, 1, 0, 0, 0, 1, 0, 32'h10, 0);
    chk("rstf_cpu_first", dbg_gnt, 0);
    chk("rstf_nostall", cpu_stall, 0);

    // Misaligned debug write to 0x06.
    drive(1, 0, 0, 0, 0, 1, 1, 32'h06, 9);
    chk("mis_gnt", dbg_gnt, 1);
`ifdef DMEM_ALIGN_CHK_EN
    chk("mis_we", mem_we, 0);
`else
    chk("mis_we", mem_we, 1);
`endif
    drive(1, 1, 0, 32'h04, 0, 0, 0, 0, 0);
`ifdef DMEM_ALIGN_CHK_EN
    chk("mis_mem1", cpu_rdata, 6);
    chk("mis_err", err, 1);
`else
    chk("mis_mem1", cpu_rdata, 9);
    chk("mis_err", err, 0);
`endif
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", err, ALIGN);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_cleared", err, 0);

    // Random traffic against the reference model.
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; last_gnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!d_req || last_gnt) begin
        d_req   = $urandom_range(1);
        d_we    = $urandom_range(1);
        d_addr  = rnd_addr();
        d_wdata = $urandom;
      end
      drive(($urandom_range(39) != 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
            rnd_addr(), $urandom, d_req, d_we, d_addr, d_wdata);
      chk_model();
      last_gnt = e_gnt;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
